dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Sits directly downstream of the core's memory stage.
- Converts the M-stage data-side signals into an SRAM-like split-transaction bus:
  - address handshake `addr_ok`;
  - data handshake `data_ok`.
- Converts the M-stage signals used: byte-enable write mask, ALU address, store data, read enable.
- Holds the pipeline with `stall` until the access completes.
- Returns load data on `readdata`, which feeds the core's `readdataM`.

Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; fixed at 32 for byte-enable decoding.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `memen`  in  1  M-stage access enable; a read when `memwrite==0`.
- `memwrite`  in  4  byte-enable write mask from M stage; nonzero means store.
- `addr`  in  `AW`  M-stage ALU result, used as the byte address.
- `writedata`  in  `DW`  store data, already byte-lane aligned.
- `readdata`  out  `DW`  load data to the M/W boundary.
- `stall`  out  1  pipeline hold request to hazard logic.
- `bus_req`  out  1  bus request.
- `bus_wr`  out  1  1 = write.
- `bus_size`  out  2  0 = byte, 1 = half, 2 = word.
- `bus_addr`  out  `AW`  bus address.
- `bus_wdata`  out  `DW`  bus write data.
- `bus_addr_ok`  in  1  slave accepted address (request handshake).
- `bus_data_ok`  in  1  read data valid, or write complete.
- `bus_rdata`  in  `DW`  bus read data.

Behaviour:
- Access condition: `access = memen | (|memwrite)`.
- States: IDLE, REQ, WAIT, DONE (2-bit register).
- Reset (`rst` low, async):
  - state = IDLE;
  - `readdata` = 0;
  - all `bus_*` outputs = 0;
  - `stall` = 0.
- IDLE:
  - If `access`, go to REQ.
  - Latch `bus_addr`, `bus_wr`, `bus_size`, `bus_wdata` into registers on the same edge.
  - `stall` = `access` (combinational, same cycle).
- REQ:
  - `bus_req` = 1.
  - Request fields are held stable until `bus_addr_ok` is sampled high.
  - On `bus_addr_ok`: go to WAIT.
  - If `bus_addr_ok` and `bus_data_ok` are both high in the same cycle: go to DONE directly, capturing `bus_rdata`.
  - `stall` = 1.
- WAIT:
  - `bus_req` = 0.
  - On `bus_data_ok`: capture `bus_rdata` into `readdata` (reads only; writes leave `readdata` unchanged), then go to DONE.
  - `stall` = 1.
- DONE:
  - `stall` = 0 for exactly one cycle, so the pipeline advances and consumes `readdata`.
  - Go unconditionally to IDLE. The same M instruction is never re-issued.
  - A new access appearing in the next cycle starts from IDLE.
- Size/address decode for writes:
  - `memwrite` 1111 → size 2, `addr[1:0]` forced to 00.
  - 0011 → size 1, offset 00.
  - 1100 → size 1, offset 10.
  - Single-hot mask → size 0, offset = index of the set bit.
  - Any other mask → treated as word (size 2, offset 00).
- Reads: always size 2, `addr[1:0]` forced to 00. Byte/half extraction is done downstream.
- Ignored inputs: `bus_data_ok` in IDLE or DONE is ignored; `bus_addr_ok` outside REQ is ignored.
- `readdata` holds its value until the next completed read.
- Reset asserted mid-transaction: abort immediately to IDLE, with no further `bus_req`. Slave-side cleanup is the slave's responsibility.

Optional Feature:
- Macro: `DMEM_POSTED_WRITE_EN`.
- When defined:
  - Writes complete from the core's view on `bus_addr_ok`: REQ → DONE directly, and the `data_ok` wait is skipped.
  - A 1-bit outstanding-write flag is set on that edge and cleared by `bus_data_ok`.
  - A new access arriving in IDLE while the flag is set keeps `stall` = 1 and waits in IDLE until the flag clears.
- When not defined: writes wait for `bus_data_ok` exactly like reads.

Decomposition:
- Shared package `dmem_pkg`:
  - state encoding constants: IDLE=0, REQ=1, WAIT=2, DONE=3;
  - size constants: `SZ_B`, `SZ_H`, `SZ_W`.
- Sub-module `dmem_size_dec` (combinational): maps `{memwrite, addr[1:0]}` to `{bus_size, bus_addr[1:0]}`.
- FSM and registers stay in `dmem_bridge`.

Test Plan:
- Word store:
  - Stimulus: `memwrite`=1111, `addr`=0x100, `writedata`=0xDEADBEEF; `addr_ok` after 2 cycles, `data_ok` after 1 more.
  - Required: `bus_req` high for 3 cycles with `bus_wr`=1, `size`=2, `bus_addr`=0x100; `stall` high until DONE, low for exactly one cycle.
- Load:
  - Stimulus: `memen`=1, `addr`=0x203; same-cycle `addr_ok` and `data_ok` with `rdata`=0x12345678.
  - Required: `bus_addr`=0x200, `size`=2; `readdata`=0x12345678 from DONE onward and held afterwards.
- Byte store:
  - Stimulus: `memwrite`=0100, `addr`=0x40.
  - Required: `bus_size`=0, `bus_addr`=0x42.
  - Stimulus: `memwrite`=1100.
  - Required: `size`=1, `bus_addr`=0x42.
- Back-to-back accesses:
  - Stimulus: two consecutive loads.
  - Required: exactly two bus requests, one DONE cycle between them; no duplicate issue.
- Reset mid-transfer:
  - Stimulus: `rst` low during WAIT.
  - Required: `stall`, `bus_req`, `readdata` = 0 asynchronously; state IDLE; a later `data_ok` is ignored.
- Posted write (`DMEM_POSTED_WRITE_EN`):
  - Stimulus: store gets `addr_ok`, `data_ok` delayed 4 cycles, and a load follows immediately.
  - Required: store's `stall` drops after `addr_ok`; load stalls in IDLE until `data_ok`, then issues.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory bridge: FSM state encoding, bus size codes
// and the size/offset decode result.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] offset;
    } sizeDec_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// SRAM-like split-transaction bus: address handshake (addr_ok) and
// data handshake (data_ok). The bridge is the master.
interface dmem_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/dmem_size_dec.sv
// Maps the M-stage byte-enable mask to a bus transfer size and the low two
// address bits. Reads (mask 0) and irregular masks fall back to a word access.
module dmem_size_dec
    import dmem_pkg::*;
(
    input  logic [3:0] memwrite,
    output sizeDec_t   dec
);

    always_comb begin
        dec = '{size: SZ_W, offset: 2'b00};
        case (memwrite)
            4'b0011: dec = '{size: SZ_H, offset: 2'b00};
            4'b1100: dec = '{size: SZ_H, offset: 2'b10};
            4'b0001: dec = '{size: SZ_B, offset: 2'b00};
            4'b0010: dec = '{size: SZ_B, offset: 2'b01};
            4'b0100: dec = '{size: SZ_B, offset: 2'b10};
            4'b1000: dec = '{size: SZ_B, offset: 2'b11};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from the M-stage data-side signals to the split-transaction bus,
// holding the pipeline until each access completes. Optional: DMEM_POSTED_WRITE_EN.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memen,
    input  logic [3:0]    memwrite,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic          stall,
    dmem_bridge_if.master bus
);

    state_t        state, nextState;
    sizeDec_t      dec;
    logic          access;
    logic          loadReq;
    logic          captureRd;
    logic          stallRaw;
    logic          postedBusy;
    logic [AW-1:0] addrQ;
    logic          wrQ;
    logic [1:0]    sizeQ;
    logic [DW-1:0] wdataQ;

    assign access = memen | (|memwrite);

    dmem_size_dec u_size_dec (
        .memwrite (memwrite),
        .dec      (dec)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

`ifdef DMEM_POSTED_WRITE_EN
    logic postedSet;

    // Write accepted by the slave but its data_ok not yet seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 postedBusy <= 1'b0;
        else if (postedSet)       postedBusy <= 1'b1;
        else if (bus.bus_data_ok) postedBusy <= 1'b0;
    end
`else
    assign postedBusy = 1'b0;
`endif

    // NOTE: every output gets a default first so no branch infers a latch.
    always_comb begin
        nextState = state;
        loadReq   = 1'b0;
        captureRd = 1'b0;
        stallRaw  = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
        postedSet = 1'b0;
`endif
        case (state)
            IDLE: begin
                stallRaw = access;
                if (access && !postedBusy) begin
                    nextState = REQ;
                    loadReq   = 1'b1;
                end
            end
            REQ: begin
                stallRaw = 1'b1;
                if (bus.bus_addr_ok) begin
                    if (bus.bus_data_ok) begin
                        nextState = DONE;
                        captureRd = ~wrQ;
                    end
`ifdef DMEM_POSTED_WRITE_EN
                    else if (wrQ) begin
                        nextState = DONE;
                        postedSet = 1'b1;
                    end
`endif
                    else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                stallRaw = 1'b1;
                if (bus.bus_data_ok) begin
                    nextState = DONE;
                    captureRd = ~wrQ;
                end
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE and held through the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrQ    <= '0;
            wrQ      <= 1'b0;
            sizeQ    <= SZ_B;
            wdataQ   <= '0;
            readdata <= '0;
        end else begin
            if (loadReq) begin
                addrQ  <= (addr & ~AW'(3)) | AW'(dec.offset);
                wrQ    <= |memwrite;
                sizeQ  <= dec.size;
                wdataQ <= writedata;
            end
            if (captureRd) readdata <= bus.bus_rdata;
        end
    end

    // Reset must drop the hold even while the pipeline still presents an access.
    assign stall         = rst & stallRaw;
    assign bus.bus_req   = (state == REQ);
    assign bus.bus_wr    = wrQ;
    assign bus.bus_size  = sizeQ;
    assign bus.bus_addr  = addrQ;
    assign bus.bus_wdata = wdataQ;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: reactive slave model with random
// latencies and idle-cycle noise, checked against a spec-level reference.
`timescale 1ns/1ps
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memen = 1'b0;
    logic [3:0]  memwrite = 4'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        stall;

    int checks = 0;
    int failures = 0;

    logic [31:0] modelRd = '0;

    // Slave configuration for the current access
    int          cfgADelay = 0;
    bit          cfgSame = 1'b0;
    int          cfgDDelay = 0;
    logic [31:0] cfgRdata = '0;
    bit          noiseEn = 1'b0;

    // Slave state (written only by the slave process)
    int reqCnt = 0;
    int pend = -1;
    int negCnt = 0;
    int lateOkCyc = -1;
    int accepts = 0;

    dmem_bridge_if #(.AW(32), .DW(32)) bus ();

    dmem_bridge #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .memen     (memen),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reactive slave: accepts the address after cfgADelay extra request
    // cycles, answers data after cfgDDelay+1 further cycles (or in the same
    // cycle), and optionally toggles handshakes at random while the bus is idle.
    initial begin
        bit fired;
        bus.bus_addr_ok = 1'b0;
        bus.bus_data_ok = 1'b0;
        bus.bus_rdata   = '0;
        forever begin
            @(negedge clk);
            negCnt++;
            fired = 1'b0;
            bus.bus_addr_ok = 1'b0;
            bus.bus_data_ok = 1'b0;
            bus.bus_rdata   = $urandom;
            if (pend == 0) begin
                bus.bus_data_ok = 1'b1;
                bus.bus_rdata   = cfgRdata;
                pend = -1;
                lateOkCyc = negCnt;
                fired = 1'b1;
            end else if (pend > 0) begin
                pend--;
            end
            if (bus.bus_req === 1'b1) begin
                reqCnt++;
                if (reqCnt == cfgADelay + 1) begin
                    bus.bus_addr_ok = 1'b1;
                    reqCnt = 0;
                    accepts++;
                    if (cfgSame) begin
                        bus.bus_data_ok = 1'b1;
                        bus.bus_rdata   = cfgRdata;
                    end else begin
                        pend = cfgDDelay;
                    end
                end
            end else if (noiseEn && pend < 0 && !fired) begin
                bus.bus_addr_ok = 1'($urandom_range(0, 1));
                bus.bus_data_ok = ($urandom_range(0, 2) == 0);
            end
        end
    end

    // Expected bus size and address from the byte-enable mask.
    function automatic void model_req(input logic [3:0] mw, input logic [31:0] a,
                                      output logic [1:0] sz, output logic [31:0] ba);
        sz = 2'd2;
        ba = a - (a % 4);
        if (mw == 4'b0011) begin
            sz = 2'd1;
        end else if (mw == 4'b1100) begin
            sz = 2'd1;
            ba = ba + 32'd2;
        end else if ($countones(mw) == 1) begin
            sz = 2'd0;
            for (int i = 0; i < 4; i++) if (mw[i]) ba = ba + 32'(i);
        end
    endfunction

    // Cycles the pipeline is held: the IDLE cycle, every request cycle and,
    // unless data came with the address (or the write is posted), the wait.
    function automatic int exp_stall(input bit isWr, input int aD, input bit same, input int dD);
        int n;
        n = 1 + aD + 1;
`ifdef DMEM_POSTED_WRITE_EN
        if (isWr) return n;
`endif
        if (!same) n += dD + 1;
        return n;
    endfunction

    // Present one access at the current negedge and follow it to its DONE
    // cycle; returns at the negedge after DONE with the access still driven.
    task automatic do_access(input logic men, input logic [3:0] mw, input logic [31:0] a,
                             input logic [31:0] wd, input int aD, input bit same, input int dD,
                             input logic [31:0] rd, input bit chkStall,
                             output int stallCyc, output int firstReq,
                             output logic [31:0] obsAddr, output logic [1:0] obsSize);
        logic [1:0]  eSize;
        logic [31:0] eAddr;
        bit          isWr;
        bit          done;
        int          reqCyc;
        isWr = (mw != 4'b0000);
        model_req(mw, a, eSize, eAddr);
        cfgADelay = aD; cfgSame = same; cfgDDelay = dD; cfgRdata = rd;
        memen = men; memwrite = mw; addr = a; writedata = wd;
        stallCyc = 0; reqCyc = 0; firstReq = -1; done = 1'b0;
        obsAddr = 'x; obsSize = 'x;
        for (int c = 0; c < 80 && !done; c++) begin
            #2;
            if (c == 0) begin
                checks++;
                if (stall !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_on_access: stall=%b required 1", stall);
                end
            end
            if (bus.bus_req === 1'b1) begin
                reqCyc++;
                if (firstReq < 0) begin
                    firstReq = negCnt;
                    obsAddr  = bus.bus_addr;
                    obsSize  = bus.bus_size;
                end
                checks++;
                if (bus.bus_wr !== isWr || bus.bus_size !== eSize ||
                    bus.bus_addr !== eAddr || bus.bus_wdata !== wd) begin
                    failures++;
                    $display("FAIL req_fields: wr=%b size=%0d addr=%h wdata=%h required wr=%b size=%0d addr=%h wdata=%h",
                             bus.bus_wr, bus.bus_size, bus.bus_addr, bus.bus_wdata, isWr, eSize, eAddr, wd);
                end
            end
            if (stall === 1'b1) stallCyc++;
            else done = 1'b1;
            if (!done) @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_timeout: stall still %b after 80 cycles, required 0", stall);
        end
        checks++;
        if (reqCyc != aD + 1) begin
            failures++;
            $display("FAIL req_cycles: got %0d required %0d", reqCyc, aD + 1);
        end
        if (chkStall) begin
            checks++;
            if (stallCyc != exp_stall(isWr, aD, same, dD)) begin
                failures++;
                $display("FAIL stall_cycles: got %0d required %0d", stallCyc, exp_stall(isWr, aD, same, dD));
            end
        end
        if (!isWr) modelRd = rd;
        checks++;
        if (readdata !== modelRd) begin
            failures++;
            $display("FAIL readdata_done: got %h required %h", readdata, modelRd);
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        memen = 1'b0; memwrite = 4'b0; addr = $urandom; writedata = $urandom;
        for (int c = 0; c < n; c++) begin
            #2;
            checks++;
            if (stall !== 1'b0 || bus.bus_req !== 1'b0 || readdata !== modelRd) begin
                failures++;
                $display("FAIL idle: stall=%b req=%b readdata=%h required 0 0 %h",
                         stall, bus.bus_req, readdata, modelRd);
            end
            @(negedge clk);
        end
    endtask

    // Let any outstanding slave response finish before the next access.
    task automatic drain();
        int guard;
        guard = 0;
        while (pend >= 0 && guard < 40) begin
            idle_cycles(1);
            guard++;
        end
        checks++;
        if (pend >= 0) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d required -1", pend);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset();
        memen = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (stall !== 1'b0 || readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_core: stall=%b readdata=%h required 0 0", stall, readdata);
        end
        checks++;
        if (bus.bus_req !== 1'b0 || bus.bus_wr !== 1'b0 || bus.bus_size !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b wr=%b size=%0d required 0 0 0", bus.bus_req, bus.bus_wr, bus.bus_size);
        end
        checks++;
        if (bus.bus_addr !== 32'h0 || bus.bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h required 0 0", bus.bus_addr, bus.bus_wdata);
        end
        @(negedge clk);
        memen = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_word_store();
        int sc, fr; logic [31:0] oa; logic [1:0] os;
        do_access(1'b0, 4'b1111, 32'h100, 32'hDEADBEEF, 2, 1'b0, 0, $urandom, 1'b1, sc, fr, oa, os);
        checks++;
        if (oa !== 32'h100 || os !== 2'd2) begin
            failures++;
            $display("FAIL word_store: addr=%h size=%0d required 00000100 2", oa, os);
        end
        drain();
    endtask

    task automatic test_load();
        int sc, fr; logic [31:0] oa; logic [1:0] os;
        do_access(1'b1, 4'b0000, 32'h203, $urandom, 0, 1'b1, 0, 32'h12345678, 1'b1, sc, fr, oa, os);
        checks++;
        if (oa !== 32'h200 || os !== 2'd2 || readdata !== 32'h12345678) begin
            failures++;
            $display("FAIL load: addr=%h size=%0d readdata=%h required 00000200 2 12345678", oa, os, readdata);
        end
        idle_cycles(3);
    endtask

    task automatic test_byte_store();
        int sc, fr; logic [31:0] oa; logic [1:0] os;
        do_access(1'b0, 4'b0100, 32'h40, $urandom, 1, 1'b0, 1, $urandom, 1'b1, sc, fr, oa, os);
        checks++;
        if (oa !== 32'h42 || os !== 2'd0) begin
            failures++;
            $display("FAIL byte_store: addr=%h size=%0d required 00000042 0", oa, os);
        end
        drain();
        do_access(1'b1, 4'b1100, 32'h40, $urandom, 0, 1'b1, 0, $urandom, 1'b1, sc, fr, oa, os);
        checks++;
        if (oa !== 32'h42 || os !== 2'd1) begin
            failures++;
            $display("FAIL half_store: addr=%h size=%0d required 00000042 1", oa, os);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int sc, fr, acc0; logic [31:0] oa; logic [1:0] os;
        acc0 = accepts;
        do_access(1'b1, 4'b0000, 32'h500, $urandom, 0, 1'b0, 1, 32'hCAFE0001, 1'b1, sc, fr, oa, os);
        do_access(1'b1, 4'b0000, 32'h504, $urandom, 0, 1'b0, 0, 32'hCAFE0002, 1'b1, sc, fr, oa, os);
        idle_cycles(3);
        checks++;
        if (accepts - acc0 != 2) begin
            failures++;
            $display("FAIL back_to_back_requests: got %0d required 2", accepts - acc0);
        end
    endtask

`ifdef DMEM_POSTED_WRITE_EN
    task automatic test_posted();
        int sc, fr, sc2, fr2; logic [31:0] oa; logic [1:0] os;
        do_access(1'b0, 4'b1111, 32'h300, 32'h0BADF00D, 0, 1'b0, 3, $urandom, 1'b1, sc, fr, oa, os);
        checks++;
        if (sc != 2) begin
            failures++;
            $display("FAIL posted_store_stall: got %0d required 2", sc);
        end
        do_access(1'b1, 4'b0000, 32'h304, $urandom, 0, 1'b1, 0, 32'h600DD00D, 1'b0, sc2, fr2, oa, os);
        checks++;
        if (fr2 != lateOkCyc + 2) begin
            failures++;
            $display("FAIL posted_load_issue: request cycle %0d required %0d", fr2, lateOkCyc + 2);
        end
        idle_cycles(2);
    endtask
`endif

    task automatic test_random();
        logic [3:0] masks [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int sc, fr; logic [31:0] oa; logic [1:0] os;
        logic [3:0] mw; logic men;
        noiseEn = 1'b1;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0:       begin men = 1'b1; mw = 4'b0000; end
                1:       begin men = 1'($urandom_range(0, 1)); mw = masks[$urandom_range(0, 6)]; end
                default: begin men = 1'($urandom_range(0, 1)); mw = 4'($urandom_range(1, 15)); end
            endcase
            do_access(men, mw, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom, 1'b1, sc, fr, oa, os);
            if ($urandom_range(0, 2) != 0 || pend >= 0) begin
                idle_cycles($urandom_range(0, 2));
                drain();
            end
        end
        noiseEn = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int sc, fr; logic [31:0] oa; logic [1:0] os;
        do_access(1'b1, 4'b0000, 32'h700, $urandom, 0, 1'b1, 0, 32'hA5A50F0F, 1'b1, sc, fr, oa, os);
        cfgADelay = 0; cfgSame = 1'b0; cfgDDelay = 4; cfgRdata = 32'hFFFF0000;
        memen = 1'b1; memwrite = 4'b0000; addr = 32'h800;
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (stall !== 1'b1 || bus.bus_req !== 1'b0 || readdata !== 32'hA5A50F0F) begin
            failures++;
            $display("FAIL wait_state: stall=%b req=%b readdata=%h required 1 0 a5a50f0f", stall, bus.bus_req, readdata);
        end
        #1 rst = 1'b0;
        #1;
        modelRd = '0;
        checks++;
        if (stall !== 1'b0 || bus.bus_req !== 1'b0 || readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: stall=%b req=%b readdata=%h required 0 0 0", stall, bus.bus_req, readdata);
        end
        @(negedge clk);
        memen = 1'b0;
        rst = 1'b1;
        idle_cycles(6);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_word_store();
        test_load();
        test_byte_store();
        test_back_to_back();
`ifdef DMEM_POSTED_WRITE_EN
        test_posted();
`endif
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
